// File: rtl/fifo_arb_pkg.sv
// Shared encodings, default sizes and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  localparam int NREQ_DEF      = 4;
  localparam int DW_DEF        = 8;
  localparam int MAX_BURST_DEF = 16;

  // Smallest beat-counter width whose range strictly exceeds max_burst.
  function automatic int cw_for(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

  localparam int CW_DEF = cw_for(MAX_BURST_DEF);
endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-side write signals of the arbiter, bundled for port lists.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF
);
  // A beat on requester i moves on the rising edge where req_valid[i] and
  // req_ready[i] are both high; ready never waits on valid. fifo_wr/fifo_d
  // are sampled by the FIFO on that same edge.
  logic [NREQ-1:0]    req_en;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_last;
  logic [NREQ-1:0]    req_ready;
  logic               fifo_full;
  logic               fifo_wr;
  logic [DW-1:0]      fifo_d;

  modport master (
    output req_en, req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wr, fifo_d
  );

  modport slave (
    input  req_en, req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wr, fifo_d
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set bit of eligible above rr_ptr, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [IW-1:0]   rr_ptr,
  output logic [IW-1:0]   sel,
  output logic            any
);
  always_comb begin
    sel = '0;
    any = 1'b0;
    // Walk from the farthest offset to the nearest so the nearest hit is kept.
    for (int k = NREQ; k >= 1; k--) begin
      if (eligible[IW'((int'(rr_ptr) + k) % NREQ)]) begin
        sel = IW'((int'(rr_ptr) + k) % NREQ);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the async FIFO write port among NREQ producers.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int CW        = cw_for(MAX_BURST)
) (
  input  logic             wr_clk_in,
  input  logic             rst,
  fifo_wr_arbiter_if.slave bus,
  output logic [NREQ-1:0]  grant_oh,
  output logic             busy,
  output logic [CW-1:0]    beat_cnt
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [0:0]      state;
  logic [IW-1:0]   g_idx;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   sel;
  logic            any;
  logic            xfer;
  logic            burst_end;
  logic [NREQ-1:0] eligible;

  assign eligible = bus.req_valid & bus.req_en;
  assign busy     = (state == BURST);

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .sel      (sel),
    .any      (any)
  );

  // Only the granted requester sees ready, and only while the FIFO has room.
  always_comb begin
    bus.req_ready = '0;
    bus.fifo_d    = '0;
    xfer          = 1'b0;
    if (state == BURST) begin
      for (int i = 0; i < NREQ; i++) begin
        if (g_idx == IW'(i)) begin
          bus.req_ready[i] = ~bus.fifo_full;
          bus.fifo_d       = bus.req_data[i*DW +: DW];
        end
      end
      xfer = bus.req_valid[g_idx] & ~bus.fifo_full;
    end
    bus.fifo_wr = xfer;
    burst_end   = xfer & (bus.req_last[g_idx] | (beat_cnt == CW'(MAX_BURST - 1)));
  end

  always_ff @(posedge wr_clk_in or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      g_idx    <= '0;
      rr_ptr   <= IW'(NREQ - 1);
      grant_oh <= '0;
      beat_cnt <= '0;
    end else if (state == IDLE) begin
      if (any) begin
        state    <= BURST;
        g_idx    <= sel;
        rr_ptr   <= sel;
        grant_oh <= NREQ'(1) << sel;
        beat_cnt <= '0;
      end
    end else begin
      if (burst_end) begin
        state    <= IDLE;
        grant_oh <= '0;
        beat_cnt <= '0;
      end else if (xfer) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized traffic.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int MAXB = 16;
  localparam int C    = CW_DEF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0] grant_oh;
  logic         busy;
  logic [C-1:0] beat_cnt;

  fifo_wr_arbiter_if #(.NREQ(N), .DW(W)) bus ();

  fifo_wr_arbiter #(.NREQ(N), .DW(W), .MAX_BURST(MAXB), .CW(C)) dut (
    .wr_clk_in (clk),
    .rst       (rst),
    .bus       (bus),
    .grant_oh  (grant_oh),
    .busy      (busy),
    .beat_cnt  (beat_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Producer beat stores, one per requester.
  logic [W-1:0] data_mem [N][256];
  bit           last_mem [N][256];
  int           rd   [N];
  int           wr_n [N];

  logic [N-1:0] cur_en;
  logic [N-1:0] cur_valid;
  bit           cur_full;
  bit           full_force;
  int           valid_prob;
  int           full_prob;

  // Reference model: burst in progress, owner, last owner, beats in burst.
  bit           m_busy;
  logic [1:0]   m_g;
  logic [1:0]   m_ptr;
  int           m_cnt;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] wr_log[$];
  int           wr_cyc[$];
  int           gnt_log[$];
  int           blen_log[$];
  int           cyc = 0;
  bit           prev_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] rr_next(input logic [1:0] last, input logic [N-1:0] mask);
    for (int k = 1; k <= N; k++) begin
      int idx = (int'(last) + k) % N;
      if (mask[idx]) return 2'(idx);
    end
    return last;
  endfunction

  function automatic bit drained();
    if (m_busy) return 1'b0;
    for (int i = 0; i < N; i++)
      if (cur_en[i] && rd[i] < wr_n[i]) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load(input int i, input int n, input logic [W-1:0] base, input int blen);
    for (int k = 0; k < n; k++) begin
      data_mem[i][wr_n[i]] = base + W'(k);
      last_mem[i][wr_n[i]] = (k == n - 1) || (blen != 0 && (k + 1) % blen == 0);
      wr_n[i]++;
    end
  endtask

  task automatic drive_inputs();
    logic [N*W-1:0] dv;
    logic [N-1:0]   lv;
    dv        = '0;
    lv        = '0;
    cur_valid = '0;
    for (int i = 0; i < N; i++) begin
      if (rd[i] < wr_n[i]) begin
        cur_valid[i]  = ($urandom_range(0, 99) < valid_prob);
        dv[i*W +: W]  = data_mem[i][rd[i]];
        lv[i]         = last_mem[i][rd[i]];
      end
    end
    cur_full      = full_force || ($urandom_range(0, 99) < full_prob);
    bus.req_en    = cur_en;
    bus.req_valid = cur_valid;
    bus.req_data  = dv;
    bus.req_last  = lv;
    bus.fifo_full = cur_full;
  endtask

  task automatic model_reset();
    m_busy    = 1'b0;
    m_g       = 2'd0;
    m_ptr     = 2'(N - 1);
    m_cnt     = 0;
    prev_busy = 1'b0;
    exp_q.delete();
    wr_log.delete();
    wr_cyc.delete();
    gnt_log.delete();
    blen_log.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      rd[i]   = 0;
      wr_n[i] = 0;
    end
    cur_en     = '1;
    full_force = 1'b0;
    full_prob  = 0;
    valid_prob = 100;
    drive_inputs();
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  // One clock: drive, check against the model, advance the model, take the edge.
  task automatic cycle();
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_g;
    logic [N-1:0] elig;
    bit           xfer;
    bit           lst;
    int           g;
    drive_inputs();
    #2;
    exp_ready = '0;
    exp_g     = '0;
    xfer      = 1'b0;
    if (m_busy) begin
      exp_g[m_g] = 1'b1;
      if (!cur_full) exp_ready[m_g] = 1'b1;
      xfer = cur_valid[m_g] && !cur_full;
    end
    chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    chk("fifo_wr", 32'(bus.fifo_wr), 32'(xfer));
    chk("grant_oh", 32'(grant_oh), 32'(exp_g));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("beat_cnt", 32'(beat_cnt), 32'(m_cnt));
    chk("inv_onehot", 32'($onehot0(grant_oh)), 32'(1));
    chk("inv_busy_grant", 32'(busy), 32'(grant_oh != '0));
    chk("inv_ready_max1", 32'($countones(bus.req_ready) <= 1), 32'(1));
    chk("inv_wr_full", 32'(bus.fifo_wr & bus.fifo_full), 32'(0));
    if (xfer) exp_q.push_back(data_mem[m_g][rd[m_g]]);
    if (bus.fifo_wr === 1'b1) begin
      if (exp_q.size() == 0) chk("wr_unexpected", 32'(exp_q.size()), 32'(1));
      else chk("fifo_d", 32'(bus.fifo_d), 32'(exp_q.pop_front()));
      wr_log.push_back(bus.fifo_d);
      wr_cyc.push_back(cyc);
      if (blen_log.size() > 0)
        blen_log[blen_log.size()-1] = blen_log[blen_log.size()-1] + 1;
    end
    if (!m_busy) begin
      elig = cur_valid & cur_en;
      if (elig != '0) begin
        m_g    = rr_next(m_ptr, elig);
        m_ptr  = m_g;
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end else if (xfer) begin
      lst = last_mem[m_g][rd[m_g]];
      rd[m_g]++;
      m_cnt++;
      if (lst || m_cnt == MAXB) begin
        m_busy = 1'b0;
        m_cnt  = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (busy === 1'b1 && !prev_busy) begin
      g = -1;
      for (int k = 0; k < N; k++) if (grant_oh[k]) g = k;
      gnt_log.push_back(g);
      blen_log.push_back(0);
    end
    prev_busy = (busy === 1'b1);
  endtask

  task automatic run_drain(input int bound, input string tag);
    int n = 0;
    while (!drained() && n < bound) begin
      cycle();
      n++;
    end
    chk(tag, 32'(drained()), 32'(1));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    int total;
    int cnt;

    // Reset state, with requesters already shouting.
    bus.req_en    = '1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.fifo_full = 1'b0;
    #1;
    rst = 1'b0;
    bus.req_valid = '1;
    #2;
    chk("rst_grant", 32'(grant_oh), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_cnt", 32'(beat_cnt), 32'(0));
    chk("rst_ready", 32'(bus.req_ready), 32'(0));
    chk("rst_wr", 32'(bus.fifo_wr), 32'(0));
    chk("rst_d", 32'(bus.fifo_d), 32'(0));
    @(posedge clk);
    #1;
    chk("rst_hold_grant", 32'(grant_oh), 32'(0));

    // Single requester, three beats A1..A3.
    do_reset();
    load(0, 3, 8'hA1, 3);
    run_drain(20, "t1_drain");
    chk("t1_ngnt", 32'(gnt_log.size()), 32'(1));
    chk("t1_gnt0", 32'(gnt_log[0]), 32'(0));
    chk("t1_nwr", 32'(wr_log.size()), 32'(3));
    chk("t1_d0", 32'(wr_log[0]), 32'(8'hA1));
    chk("t1_d1", 32'(wr_log[1]), 32'(8'hA2));
    chk("t1_d2", 32'(wr_log[2]), 32'(8'hA3));
    chk("t1_consec", 32'(wr_cyc[2] - wr_cyc[0]), 32'(2));

    // Round-robin fairness: two 2-beat bursts each.
    do_reset();
    for (int i = 0; i < N; i++) load(i, 4, 8'(8'h10 * (i + 1)), 2);
    run_drain(100, "t2_drain");
    chk("t2_ngnt", 32'(gnt_log.size()), 32'(8));
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t2_gnt%0d", k), 32'(gnt_log[k]), 32'(k % N));
      chk($sformatf("t2_blen%0d", k), 32'(blen_log[k]), 32'(2));
    end
    chk("t2_nwr", 32'(wr_log.size()), 32'(16));

    // MAX_BURST cut: requester 2 streams 20 beats, requester 1 joins.
    do_reset();
    cur_en = 4'b0110;
    load(2, 20, 8'h20, 0);
    n = 0;
    while (busy !== 1'b1 && n < 20) begin cycle(); n++; end
    chk("t3_start", 32'(busy), 32'(1));
    load(1, 2, 8'h50, 0);
    run_drain(200, "t3_drain");
    chk("t3_ngnt", 32'(gnt_log.size()), 32'(3));
    chk("t3_gnt0", 32'(gnt_log[0]), 32'(2));
    chk("t3_gnt1", 32'(gnt_log[1]), 32'(1));
    chk("t3_gnt2", 32'(gnt_log[2]), 32'(2));
    chk("t3_blen0", 32'(blen_log[0]), 32'(MAXB));
    chk("t3_blen1", 32'(blen_log[1]), 32'(2));
    chk("t3_blen2", 32'(blen_log[2]), 32'(4));

    // FIFO full for 5 cycles at beat_cnt=3.
    do_reset();
    load(0, 8, 8'h40, 0);
    n = 0;
    while (beat_cnt !== C'(3) && n < 50) begin cycle(); n++; end
    chk("t4_reach", 32'(beat_cnt), 32'(3));
    full_force = 1'b1;
    repeat (5) begin
      cycle();
      chk("t4_cnt_hold", 32'(beat_cnt), 32'(3));
      chk("t4_wr_stall", 32'(bus.fifo_wr), 32'(0));
      chk("t4_ready_stall", 32'(bus.req_ready), 32'(0));
    end
    full_force = 1'b0;
    run_drain(50, "t4_drain");
    chk("t4_nwr", 32'(wr_log.size()), 32'(8));
    for (int k = 0; k < 8; k++)
      chk($sformatf("t4_d%0d", k), 32'(wr_log[k]), 32'(8'h40 + k));
    chk("t4_blen", 32'(blen_log[0]), 32'(8));

    // Enable mask 1010: only 1 and 3, alternating.
    do_reset();
    cur_en = 4'b1010;
    for (int i = 0; i < N; i++) load(i, 4, 8'(8'h60 + 8'h08 * i), 2);
    run_drain(100, "t5_drain");
    chk("t5_ngnt", 32'(gnt_log.size()), 32'(4));
    for (int k = 0; k < 4; k++)
      chk($sformatf("t5_gnt%0d", k), 32'(gnt_log[k]), 32'((k % 2 == 0) ? 1 : 3));

    // Async reset mid-burst at beat 5 of requester 0.
    do_reset();
    load(0, 10, 8'h70, 0);
    load(1, 2, 8'h90, 0);
    n = 0;
    while (beat_cnt !== C'(5) && n < 50) begin cycle(); n++; end
    chk("t6_reach", 32'(beat_cnt), 32'(5));
    #2;
    rst = 1'b0;
    #1;
    chk("t6_grant", 32'(grant_oh), 32'(0));
    chk("t6_busy", 32'(busy), 32'(0));
    chk("t6_cnt", 32'(beat_cnt), 32'(0));
    chk("t6_ready", 32'(bus.req_ready), 32'(0));
    chk("t6_wr", 32'(bus.fifo_wr), 32'(0));
    #2;
    rst = 1'b1;
    model_reset();
    run_drain(50, "t6_drain");
    chk("t6_ngnt", 32'(gnt_log.size()), 32'(2));
    chk("t6_gnt0", 32'(gnt_log[0]), 32'(0));
    chk("t6_gnt1", 32'(gnt_log[1]), 32'(1));
    chk("t6_blen0", 32'(blen_log[0]), 32'(5));

    // Enable dropped mid-burst: the burst still completes.
    do_reset();
    cur_en = 4'b0001;
    load(0, 4, 8'h80, 0);
    n = 0;
    while (busy !== 1'b1 && n < 20) begin cycle(); n++; end
    chk("t8_start", 32'(busy), 32'(1));
    cur_en = 4'b0000;
    run_drain(50, "t8_drain");
    chk("t8_blen", 32'(blen_log[0]), 32'(4));
    chk("t8_nwr", 32'(wr_log.size()), 32'(4));

    // Randomized traffic with valid gaps and full stalls.
    for (int ph = 0; ph < 4; ph++) begin
      do_reset();
      cur_en     = 4'($urandom_range(1, 15));
      valid_prob = 70;
      full_prob  = 25;
      total      = 0;
      for (int i = 0; i < N; i++) begin
        cnt = $urandom_range(1, 40);
        load(i, cnt, 8'($urandom), $urandom_range(0, 20));
        if (cur_en[i]) total += cnt;
      end
      run_drain(3000, $sformatf("t7_drain%0d", ph));
      chk($sformatf("t7_nwr%0d", ph), 32'(wr_log.size()), 32'(total));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the 8-bit async FIFO among NREQ requesters, all in the write clock domain.
- Grants one requester at a time for a burst: the grant holds until that requester's last beat or until MAX_BURST beats have been written.
- Drives the FIFO's wr/d_in directly and obeys its full flag.
- Sits between the write-side producers and the FIFO write interface.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 8, data width; must match the FIFO data width
- MAX_BURST, 16, maximum beats per grant before forced re-arbitration (1..256)
- CW, 5, beat counter width; must satisfy 2^CW > MAX_BURST

Ports:
- wr_clk_in  input  1  write-domain clock; all state on its rising edge
- rst  input  1  reset, asynchronous, active-low
- req_en  input  NREQ  per-requester enable mask, quasi-static; a disabled requester is never granted
- req_valid  input  NREQ  requester i has a beat on req_data
- req_data  input  NREQ*DW  requester i data in bits [i*DW +: DW]
- req_last  input  NREQ  beat on requester i is the last of its burst
- req_ready  output  NREQ  requester i's beat is accepted this cycle when its valid and ready are both high
- fifo_full  input  1  FIFO full flag (write-domain, combinational from FIFO pointers)
- fifo_wr  output  1  FIFO write strobe
- fifo_d  output  DW  FIFO write data
- grant_oh  output  NREQ  one-hot current grant (registered); all zeros when idle
- busy  output  1  high in BURST state
- beat_cnt  output  CW  beats written in the current burst

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, grant_oh=0, beat_cnt=0, busy=0.
  - rr_ptr=NREQ-1, so requester 0 has highest priority first.
  - All outputs low; fifo_d=0.
- State IDLE:
  - eligible = req_valid & req_en.
  - If eligible is non-zero, select the first eligible index searching upward from rr_ptr+1 modulo NREQ.
  - On the next edge: grant_oh=onehot(sel), rr_ptr=sel, beat_cnt=0, state=BURST.
  - Arbitration latency is 1 cycle; no beat is accepted in IDLE.
- State BURST, granted index g:
  - req_ready[g] = ~fifo_full; every other req_ready bit is 0.
  - req_ready does not depend on req_valid.
  - xfer = req_valid[g] & req_ready[g].
  - fifo_wr = xfer; fifo_d = req_data[g] (combinational, same cycle). The FIFO samples both on the same edge.
  - On xfer: beat_cnt increments.
  - End of burst: xfer with req_last[g]=1, or xfer with beat_cnt+1 == MAX_BURST.
    - On that edge: state=IDLE, grant_oh=0, beat_cnt=0.
  - Otherwise remain in BURST. The grant holds across req_valid[g] low gaps and across fifo_full stalls.
- Throughput:
  - One beat per cycle while the requester stays valid and the FIFO is not full.
  - One idle arbitration cycle between bursts.
- Boundary conditions:
  - fifo_full high: req_ready=0 and fifo_wr=0; beat_cnt and state hold.
  - fifo_wr is never high while fifo_full is high.
  - Forced end at MAX_BURST with req_last=0: the requester re-arbitrates later; the other requesters get priority first (rr_ptr=g).
  - req_en[g] deasserted mid-burst: the burst continues to completion; the mask affects only selection in IDLE.
  - A single eligible requester is granted back-to-back, with a 1-cycle IDLE gap each time.
  - rst low mid-burst: immediate return to the reset state. Partial bursts are not tracked or replayed.
- Invariants: grant_oh is one-hot or zero; at most one req_ready bit is high; busy == (grant_oh != 0).

Decomposition:
- Shared package fifo_arb_pkg:
  - state encoding: IDLE=1'b0, BURST=1'b1
  - default constants for NREQ, DW, MAX_BURST, CW
  - helper function for the CW calculation
- One sub-module, rr_pick:
  - combinational round-robin selector
  - inputs: eligible[NREQ], rr_ptr
  - outputs: sel index, any
  - reusable on the read side later.

Test Plan:
- Reset then a single requester: req_valid=4'b0001, 3 beats 0xA1,0xA2,0xA3 with last on 0xA3 -> grant_oh=0001 one cycle after valid; fifo_wr high for 3 consecutive cycles with fifo_d=A1,A2,A3; then IDLE, grant_oh=0.
- Round-robin fairness: all 4 requesters valid continuously, each burst 2 beats -> grant order 0,1,2,3,0, with a 1-cycle gap between bursts; 8 fifo_wr pulses per round.
- MAX_BURST cut: MAX_BURST=16, requester 2 streams 20 beats without last, requester 1 also valid -> exactly 16 writes, then grant moves to requester 3 (if eligible) or 1; requester 2's remaining 4 beats are written on its next grant.
- Full stall: force fifo_full=1 for 5 cycles mid-burst at beat_cnt=3 -> req_ready=0 and fifo_wr=0 for those 5 cycles; beat_cnt stays 3; streaming resumes on the cycle full drops with no beat lost or duplicated.
- Enable mask: req_en=4'b1010, all valid -> only requesters 1 and 3 are granted, alternating.
- Async reset mid-burst: assert rst low at beat 5 of a requester-0 burst, with no clock edge -> grant_oh, busy, beat_cnt, req_ready and fifo_wr go to 0 immediately. After release, the next grant goes to the lowest eligible index.
